// File: rtl/pe_array_feeder_pkg.sv
// Shared constants, FSM encoding and sizing helper for the PE array feeder.
package pe_array_feeder_pkg;

  localparam int unsigned NPU_PE_LANES        = 64;
  localparam int unsigned NPU_PE_DW           = 16;
  localparam int unsigned NPU_FEED_BEAT_LANES = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StIssue  = 3'd2,
    StDrain  = 3'd3,
    StFinish = 3'd4
  } feeder_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pe_array_feeder_if.sv
// Valid/ready beat stream used for the feeder's tile input and result output.
interface pe_array_feeder_if #(
  parameter int unsigned Width = 64
) ();

  logic [Width-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/pe_array_feeder.sv
// Per-tile sequencer: assembles beats into a lane vector, issues it to the PE array
// with a compute timeout, captures the results and streams them back out as beats.
module pe_array_feeder
  import pe_array_feeder_pkg::*;
#(
  parameter int unsigned LANES      = NPU_PE_LANES,
  parameter int unsigned DW         = NPU_PE_DW,
  parameter int unsigned BEAT_LANES = NPU_FEED_BEAT_LANES,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [7:0]            i_tile_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  pe_array_feeder_if.slave      i_in,
  pe_array_feeder_if.master     o_out,
  output logic                  o_out_last,
  output logic [LANES*DW-1:0]   o_pe_input,
  output logic                  o_pe_valid,
  input  logic                  i_pe_ready,
  input  logic                  i_pe_done,
  input  logic [LANES*DW-1:0]   i_pe_output
);

  localparam int unsigned BW     = BEAT_LANES * DW;
  localparam int unsigned NBEATS = LANES / BEAT_LANES;
  localparam int unsigned BCW    = cnt_width(NBEATS);
  localparam int unsigned TCW    = cnt_width(TIMEOUT);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(NBEATS - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT - 1);

  feeder_state_e       r_state, w_state_d;
  logic [BCW-1:0]      r_beat, w_beat_d;
  logic [7:0]          r_tiles, w_tiles_d;
  logic [TCW-1:0]      r_tmo, w_tmo_d;
  logic                r_error, w_error_d;
  logic [LANES*DW-1:0] r_pe_input;
  logic [LANES*DW-1:0] r_result;

  logic w_in_fire;
  logic w_out_fire;
  logic w_capture;
  logic w_unused;

  // The request is held regardless of array readiness; completion is signalled by pe_done.
  assign w_unused = i_pe_ready;

  assign w_in_fire  = (r_state == StLoad) && i_in.valid;
  assign w_out_fire = (r_state == StDrain) && o_out.ready;
  assign w_capture  = (r_state == StIssue) && i_pe_done;

  always_comb begin
    w_state_d = r_state;
    w_beat_d  = r_beat;
    w_tiles_d = r_tiles;
    w_tmo_d   = r_tmo;
    w_error_d = r_error;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_error_d = 1'b0;
          w_tiles_d = i_tile_count;
          w_state_d = (i_tile_count == 8'd0) ? StFinish : StLoad;
        end
      end
      StLoad: begin
        if (w_in_fire) begin
          if (r_beat == BEAT_LAST) begin
            w_beat_d  = '0;
            w_state_d = StIssue;
          end else begin
            w_beat_d = r_beat + BCW'(1);
          end
        end
      end
      StIssue: begin
        if (i_pe_done) begin
          w_tmo_d   = '0;
          w_state_d = StDrain;
        end else if (r_tmo == TMO_LAST) begin
          w_tmo_d   = '0;
          w_error_d = 1'b1;
          w_state_d = StFinish;
        end else begin
          w_tmo_d = r_tmo + TCW'(1);
        end
      end
      StDrain: begin
        if (w_out_fire) begin
          if (r_beat == BEAT_LAST) begin
            w_beat_d  = '0;
            w_tiles_d = r_tiles - 8'd1;
            w_state_d = (r_tiles == 8'd1) ? StFinish : StLoad;
          end else begin
            w_beat_d = r_beat + BCW'(1);
          end
        end
      end
      StFinish: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_beat  <= '0;
      r_tiles <= '0;
      r_tmo   <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_beat  <= w_beat_d;
      r_tiles <= w_tiles_d;
      r_tmo   <= w_tmo_d;
      r_error <= w_error_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pe_input <= '0;
      r_result   <= '0;
    end else begin
      if (w_in_fire) begin
        r_pe_input[int'(r_beat)*BW +: BW] <= i_in.data;
      end
      if (w_capture) begin
        r_result <= i_pe_output;
      end
    end
  end

  assign o_busy     = (r_state == StLoad) || (r_state == StIssue) || (r_state == StDrain);
  assign o_done     = (r_state == StFinish);
  assign o_error    = r_error;
  assign i_in.ready = (r_state == StLoad);
  assign o_pe_valid = (r_state == StIssue);
  assign o_pe_input = r_pe_input;

  // Output beat is forced to zero outside DRAIN so idle/reset outputs read as zero.
  assign o_out.valid = (r_state == StDrain);
  assign o_out.data  = (r_state == StDrain) ? r_result[int'(r_beat)*BW +: BW] : '0;
  assign o_out_last  = (r_state == StDrain) && (r_beat == BEAT_LAST);

endmodule

// File: tb/tb_pe_array_feeder.sv
// Scoreboard bench for pe_array_feeder: directed tiles, backpressure, timeout, reset.
module tb_pe_array_feeder;

  localparam int unsigned BW = 64;
  localparam int unsigned VW = 1024;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        job_end;
    logic [3:0]  beat;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [7:0]    tile_count;
  logic          busy, done, error, out_last;
  logic [VW-1:0] pe_input;
  logic          pe_valid;
  logic          pe_ready;
  logic          pe_done;
  logic [VW-1:0] pe_output;

  pe_array_feeder_if #(.Width(BW)) in_if ();
  pe_array_feeder_if #(.Width(BW)) out_if ();

  pe_array_feeder #(.TIMEOUT(20)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .i_tile_count(tile_count),
    .o_busy      (busy),
    .o_done      (done),
    .o_error     (error),
    .i_in        (in_if),
    .o_out       (out_if),
    .o_out_last  (out_last),
    .o_pe_input  (pe_input),
    .o_pe_valid  (pe_valid),
    .i_pe_ready  (pe_ready),
    .i_pe_done   (pe_done),
    .i_pe_output (pe_output)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   n_pop = 0;
  int   stall_cnt = 0;
  bit   stall_en = 0;
  bit   model_on = 1;
  bit   done_pending = 0;
  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_error"}, 64'(error), 0);
    check({tag, "_in_ready"}, 64'(in_if.ready), 0);
    check({tag, "_pe_valid"}, 64'(pe_valid), 0);
    check({tag, "_pe_input_nz"}, 64'(|pe_input), 0);
    check({tag, "_out_valid"}, 64'(out_if.valid), 0);
    check({tag, "_out_data"}, out_if.data, 0);
    check({tag, "_out_last"}, 64'(out_last), 0);
  endtask

  // Array model: completes after 11 accepted request cycles, result lane = 2 * input lane.
  initial begin : array_model
    int hs;
    hs = 0;
    pe_done = 1'b0;
    pe_output = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !model_on) begin
        hs = 0;
        pe_done = 1'b0;
      end else if (pe_done) begin
        pe_done = 1'b0;
      end else if (pe_valid && pe_ready) begin
        hs++;
        if (hs == 11) begin
          hs = 0;
          for (int k = 0; k < 64; k++) pe_output[k*16 +: 16] = 16'(pe_input[k*16 +: 16] * 2);
          pe_done = 1'b1;
        end
      end
    end
  end

  initial begin : out_ready_drv
    out_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        out_if.ready = 1'b0;
        stall_cnt--;
      end else begin
        out_if.ready = 1'b1;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) n_done++;
      if (done_pending) begin
        check("done_after_last_beat", {62'd0, busy, done}, 64'b01);
        done_pending = 0;
      end
      if (rst_n && out_if.valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 64'(out_if.valid), 0);
        end else begin
          e = q[0];
          check(out_if.ready ? "out_data" : "out_data_hold", out_if.data, e.data);
          check("out_last", 64'(out_last), 64'(e.last));
          if (out_if.ready) begin
            void'(q.pop_front());
            n_pop++;
            if (e.job_end) done_pending = 1;
            if (stall_en && e.beat == 4'd2) begin
              stall_cnt = 5;
              stall_en = 0;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic start_job(input logic [7:0] n);
    start = 1'b1;
    tile_count = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    tile_count = 8'hAA;
  endtask

  task automatic send_tile(input int base, input bit toggle, input bit push, input bit job_last);
    for (int b = 0; b < 16; b++) begin
      logic [63:0] d;
      logic [63:0] e;
      int g;
      for (int m = 0; m < 4; m++) begin
        d[m*16 +: 16] = 16'(base + 4*b + m);
        e[m*16 +: 16] = 16'(2 * (base + 4*b + m));
      end
      if (push) q.push_back('{data: e, last: (b == 15), job_end: (b == 15) && job_last,
                             beat: 4'(b)});
      if (toggle) begin
        in_if.valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_if.valid = 1'b1;
      in_if.data = d;
      g = 0;
      @(negedge clk);
      while (!in_if.ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (!in_if.ready) check("in_ready_timeout", 64'(in_if.ready), 1);
      @(posedge clk);
      #1;
      in_if.valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int g;
    g = 0;
    @(negedge clk);
    while (!done && g < 300) begin
      @(negedge clk);
      g++;
    end
    check(name, 64'(done), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stimulus
    int cnt, d0, p0, g;
    bit ir_seen;
    rst_n = 1'b0;
    start = 1'b0;
    tile_count = 8'd0;
    pe_ready = 1'b1;
    in_if.valid = 1'b0;
    in_if.data = '0;
    #1;
    check_reset_outputs("reset");
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(2);

    // Single tile
    start_job(8'd1);
    check("single_busy_T1", 64'(busy), 1);
    check("single_in_ready_T1", 64'(in_if.ready), 1);
    send_tile(0, 0, 1, 1);
    check("single_pe_valid_L1", 64'(pe_valid), 1);
    check("single_in_ready_L1", 64'(in_if.ready), 0);
    wait_done("single_done");
    check("single_error", 64'(error), 0);
    idle_cycles(3);

    // Backpressure on both streams
    stall_en = 1;
    start_job(8'd1);
    send_tile(1000, 1, 1, 1);
    wait_done("bp_done");
    check("bp_stall_consumed", 64'(stall_en), 0);
    idle_cycles(3);

    // Multi-tile with an ignored start mid-job
    d0 = n_done;
    p0 = n_pop;
    start_job(8'd3);
    send_tile(100, 0, 1, 0);
    start = 1'b1;
    tile_count = 8'd7;
    idle_cycles(1);
    start = 1'b0;
    send_tile(300, 0, 1, 0);
    send_tile(500, 0, 1, 1);
    wait_done("multi_done");
    idle_cycles(40);
    check("multi_done_pulses", 64'(n_done - d0), 1);
    check("multi_beats", 64'(n_pop - p0), 48);
    check("multi_idle_busy", 64'(busy), 0);

    // Timeout: array never completes
    model_on = 0;
    start_job(8'd1);
    send_tile(200, 0, 0, 1);
    cnt = 0;
    while (pe_valid && cnt < 100) begin
      cnt++;
      idle_cycles(1);
    end
    check("tmo_pe_valid_cycles", 64'(cnt), 20);
    check("tmo_error", 64'(error), 1);
    check("tmo_done", 64'(done), 1);
    idle_cycles(3);
    check("tmo_error_sticky", 64'(error), 1);
    model_on = 1;

    // Zero tiles; also clears the sticky error
    start_job(8'd0);
    check("zero_done_T1", 64'(done), 1);
    check("zero_busy_T1", 64'(busy), 0);
    check("zero_error_cleared", 64'(error), 0);
    ir_seen = in_if.ready;
    for (int i = 0; i < 5; i++) begin
      idle_cycles(1);
      ir_seen |= in_if.ready;
    end
    check("zero_in_ready_never", 64'(ir_seen), 0);

    // Reset during DRAIN at beat 7, then a clean restart
    start_job(8'd1);
    send_tile(40, 0, 1, 1);
    p0 = n_pop;
    g = 0;
    while ((n_pop - p0) < 7 && g < 200) begin
      idle_cycles(1);
      g++;
    end
    check("rst_reached_beat7", 64'(n_pop - p0), 7);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_drain_reset");
    q.delete();
    done_pending = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(2);
    start_job(8'd1);
    send_tile(7, 0, 1, 1);
    wait_done("restart_done");
    idle_cycles(3);

    check("scoreboard_empty", 64'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
